mux_scan_ctrl: RTL and testbench

//  Sequencer for a registered N:1 select tree (2^SEL_W leaves, leaf inputs registered, sel path combinational).

---
 rtl/mux_scan_pkg.sv | 17 +
 rtl/mux_scan_pack.sv | 81 ++++++++
 rtl/mux_scan_ctrl.sv | 126 ++++++++++++
 tb/tb_mux_scan_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types for the mux scan sequencer.
//   state_e      FSM states of mux_scan_ctrl
//   FILL_W       fill counter width for the default 32-bit word
//   fill_width() fill counter width for any word width (counts 0..w)
// Optional feature macro: MUX_SCAN_PARITY_EN (adds word_par output).
package mux_scan_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, SCAN, HOLD, FLUSH, DONE} state_e;

   localparam int WORD_W_DFLT = 32;
   localparam int FILL_W      = $clog2(WORD_W_DFLT + 1);

   function automatic int fill_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/mux_scan_pack.sv
// mux_scan_pack: bit packer plus one-deep output holding register.
//   push_i        take bit_i into the word at position fill
//   move_i        with push_i: the word is complete, move it (including bit_i)
//                 into the output register; caller guarantees out_free_o
//   last_i        with move: mark the moved word as final
//   full_o        next pushed bit completes a full word
//   out_free_o    output register empty or being transferred this cycle
//   word_*_o      valid/ready output word port
// Optional feature macro: MUX_SCAN_PARITY_EN (adds word_par_o).
module mux_scan_pack
   import mux_scan_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int FW     = fill_width(WORD_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic              bit_i,
   input  logic              move_i,
   input  logic              last_i,
   input  logic              word_ready_i,
   output logic              full_o,
   output logic              out_free_o,
   output logic              word_valid_o,
   output logic [WORD_W-1:0] word_data_o,
`ifdef MUX_SCAN_PARITY_EN
   output logic              word_par_o,
`endif
   output logic              word_last_o
);

   logic [WORD_W-1:0] sh_q, word_q, new_word;
   logic [FW-1:0]     fill_q;
   logic              vld_q, last_q;
`ifdef MUX_SCAN_PARITY_EN
   logic              par_q;
`endif

   // Shift register is kept zero above fill, so OR-ing in the new bit
   // leaves unused high bits of a partial word at zero.
   assign new_word   = sh_q | (WORD_W'(bit_i) << fill_q);
   assign full_o     = (fill_q == FW'(WORD_W - 1));
   assign out_free_o = !vld_q || word_ready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q   <= '0;
         fill_q <= '0;
         word_q <= '0;
         vld_q  <= 1'b0;
         last_q <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
         par_q  <= 1'b0;
`endif
      end else if (push_i && move_i) begin
         word_q <= new_word;
         vld_q  <= 1'b1;
         last_q <= last_i;
`ifdef MUX_SCAN_PARITY_EN
         par_q  <= ^new_word;
`endif
         sh_q   <= '0;
         fill_q <= '0;
      end else begin
         if (push_i) begin
            sh_q   <= new_word;
            fill_q <= fill_q + FW'(1);
         end
         if (vld_q && word_ready_i) vld_q <= 1'b0;
      end
   end

   assign word_valid_o = vld_q;
   assign word_data_o  = word_q;
   assign word_last_o  = last_q;
`ifdef MUX_SCAN_PARITY_EN
   assign word_par_o   = par_q;
`endif

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sequencer for a registered 2^SEL_W:1 select tree.
// Accepts (start, count), steps sel_o through consecutive leaves (wrapping),
// samples mux_out LAT+1 cycles after each sel_o change, packs bits LSB-first
// into WORD_W-bit words and streams them out with valid/ready backpressure.
//   clk, rst_n                 clock, async active-low reset
//   req_valid/ready/start/count scan request (ready only in IDLE)
//   sel_o, mux_out             select tree interface
//   word_valid/ready/data/last output word stream
//   busy, done                 status; done pulses once per request
// Optional feature macro: MUX_SCAN_PARITY_EN (adds word_par, XOR of word_data).
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int SEL_W  = 10,
   parameter int WORD_W = 32,
   parameter int LAT    = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [SEL_W-1:0]  req_start,
   input  logic [SEL_W:0]    req_count,
   output logic [SEL_W-1:0]  sel_o,
   input  logic              mux_out,
   output logic              word_valid,
   input  logic              word_ready,
   output logic [WORD_W-1:0] word_data,
   output logic              word_last,
   output logic              busy,
`ifdef MUX_SCAN_PARITY_EN
   output logic              word_par,
`endif
   output logic              done
);

   state_e           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d, start_q, start_d;
   logic [SEL_W:0]   rem_q, rem_d;
   logic [2:0]       settle_q, settle_d;
   logic             pk_full, pk_free;
   logic             fire, last_bit, complete, take;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         start_q  <= '0;
         rem_q    <= '0;
         settle_q <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         start_q  <= start_d;
         rem_q    <= rem_d;
         settle_q <= settle_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      start_d  = start_q;
      rem_d    = rem_q;
      settle_d = settle_q;
      // HOLD only arises from a settled SCAN cycle with sel_o unchanged,
      // so mux_out is still valid there and the held bit is sampled on release.
      fire     = ((state_q == SCAN) && (settle_q == 3'd0)) || (state_q == HOLD);
      last_bit = (rem_q == (SEL_W+1)'(1));
      complete = pk_full || last_bit;
      take     = fire && (!complete || pk_free);
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               start_d = req_start;
               rem_d   = req_count;
               state_d = (req_count == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            sel_d    = start_q;
            settle_d = 3'(LAT);
            state_d  = SCAN;
         end
         SCAN, HOLD: begin
            if ((state_q == SCAN) && (settle_q != 3'd0)) begin
               settle_d = settle_q - 3'd1;
            end else if (take) begin
               sel_d    = sel_q + SEL_W'(1);
               settle_d = 3'(LAT);
               rem_d    = rem_q - (SEL_W+1)'(1);
               state_d  = last_bit ? FLUSH : SCAN;
            end else begin
               state_d  = HOLD;
            end
         end
         FLUSH:   if (pk_free) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   mux_scan_pack #(.WORD_W(WORD_W)) u_pack (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_i       (take),
      .bit_i        (mux_out),
      .move_i       (complete),
      .last_i       (last_bit),
      .word_ready_i (word_ready),
      .full_o       (pk_full),
      .out_free_o   (pk_free),
      .word_valid_o (word_valid),
      .word_data_o  (word_data),
`ifdef MUX_SCAN_PARITY_EN
      .word_par_o   (word_par),
`endif
      .word_last_o  (word_last)
   );

   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign sel_o     = sel_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: instance dut (LAT=0) and b_dut (LAT=2).
// Tree model: leaf_q registers in_vec each clock, mux_out = leaf_q[sel_o].
module tb_mux_scan_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [1023:0] in_vec = '0;
   logic [1023:0] leaf_q = '0;
   always @(posedge clk) leaf_q <= in_vec;

   int total = 0;
   int bad   = 0;

   logic        req_valid, req_ready, mux_out, word_valid, word_ready, word_last, busy, done;
   logic [9:0]  req_start, sel_o;
   logic [10:0] req_count;
   logic [31:0] word_data;
   logic        b_req_valid, b_req_ready, b_mux_out, b_word_valid, b_word_ready, b_word_last, b_busy, b_done;
   logic [9:0]  b_req_start, b_sel_o;
   logic [10:0] b_req_count;
   logic [31:0] b_word_data;
`ifdef MUX_SCAN_PARITY_EN
   logic        word_par, b_word_par;
`endif

   assign mux_out   = leaf_q[sel_o];
   assign b_mux_out = leaf_q[b_sel_o];

   mux_scan_ctrl #(.SEL_W(10), .WORD_W(32), .LAT(0)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_start(req_start), .req_count(req_count), .sel_o(sel_o), .mux_out(mux_out),
      .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
      .word_last(word_last), .busy(busy),
`ifdef MUX_SCAN_PARITY_EN
      .word_par(word_par),
`endif
      .done(done));

   mux_scan_ctrl #(.SEL_W(10), .WORD_W(32), .LAT(2)) b_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_start(b_req_start), .req_count(b_req_count), .sel_o(b_sel_o), .mux_out(b_mux_out),
      .word_valid(b_word_valid), .word_ready(b_word_ready), .word_data(b_word_data),
      .word_last(b_word_last), .busy(b_busy),
`ifdef MUX_SCAN_PARITY_EN
      .word_par(b_word_par),
`endif
      .done(b_done));

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset;
      rst_n = 1'b0;
      @(negedge clk);
      total++; if ({sel_o, word_valid, word_last, done, busy} !== 14'd0) begin
         bad++; $display("FAIL reset_ctl: got sel=%0d v=%b l=%b d=%b b=%b want all 0", sel_o, word_valid, word_last, done, busy); end
      total++; if (word_data !== 32'd0) begin bad++; $display("FAIL reset_data: got %h want 0", word_data); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      int n;
      in_vec = '0; in_vec[31:0] = 32'hA5A5_0F0F; word_ready = 1'b1;
      @(negedge clk);
      req_start = 10'd0; req_count = 11'd32; req_valid = 1'b1;
      @(negedge clk); req_valid = 1'b0;
      n = 0;
      while (!word_valid && n < 100) begin @(negedge clk); n++; end
      total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL basic_timeout: got no word want word_valid"); end
      total++; if (word_data !== 32'hA5A5_0F0F) begin bad++; $display("FAIL basic_data: got %h want a5a50f0f", word_data); end
      total++; if (word_last !== 1'b1) begin bad++; $display("FAIL basic_last: got %b want 1", word_last); end
      @(negedge clk);
      total++; if (done !== 1'b1 || word_valid !== 1'b0) begin
         bad++; $display("FAIL basic_done: got done=%b v=%b want 1 0", done, word_valid); end
      @(negedge clk);
      total++; if (done !== 1'b0 || req_ready !== 1'b1) begin
         bad++; $display("FAIL basic_idle: got done=%b rdy=%b want 0 1", done, req_ready); end
   endtask

   task automatic test_wrap;
      int n;
      logic [9:0] exp_sel;
      in_vec = '0; in_vec[1023:1020] = 4'b1101; in_vec[3:0] = 4'b0110; word_ready = 1'b1;
      @(negedge clk);
      req_start = 10'd1020; req_count = 11'd8; req_valid = 1'b1;
      @(negedge clk); req_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         exp_sel = 10'(1020 + i);
         total++; if (sel_o !== exp_sel) begin bad++; $display("FAIL wrap_sel%0d: got %0d want %0d", i, sel_o, exp_sel); end
      end
      n = 0;
      while (!word_valid && n < 20) begin @(negedge clk); n++; end
      total++; if (word_data !== 32'h0000_006D || word_last !== 1'b1) begin
         bad++; $display("FAIL wrap_word: got %h last=%b want 0000006d last=1", word_data, word_last); end
      n = 0;
      while (busy && n < 20) begin @(negedge clk); n++; end
   endtask

   task automatic test_backpressure;
      int n, nw;
      logic [31:0] got [3];
      logic        gl  [3];
      logic [9:0]  s39;
      in_vec = '0; in_vec[31:0] = 32'h1234_5678; in_vec[63:32] = 32'hDEAD_BEEF; in_vec[69:64] = 6'h2B;
      word_ready = 1'b0;
      @(negedge clk);
      req_start = 10'd0; req_count = 11'd70; req_valid = 1'b1;
      @(negedge clk); req_valid = 1'b0;
      n = 0;
      while (!word_valid && n < 100) begin @(negedge clk); n++; end
      total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL bp_timeout: got no word want word_valid"); end
      repeat (39) @(negedge clk);
      s39 = sel_o;
      @(negedge clk);
      total++; if (sel_o !== 10'd63 || s39 !== 10'd63) begin
         bad++; $display("FAIL bp_hold_sel: got %0d,%0d want 63,63", s39, sel_o); end
      total++; if (word_valid !== 1'b1 || word_data !== 32'h1234_5678) begin
         bad++; $display("FAIL bp_hold_word: got v=%b %h want v=1 12345678", word_valid, word_data); end
      word_ready = 1'b1;
      nw = 0; n = 0;
      while (busy && n < 300) begin
         if (word_valid && word_ready) begin
            if (nw < 3) begin got[nw] = word_data; gl[nw] = word_last; end
            nw++;
         end
         @(negedge clk); n++;
      end
      total++; if (nw !== 3) begin bad++; $display("FAIL bp_count: got %0d words want 3", nw); end
      if (nw >= 3) begin
         total++; if (got[0] !== 32'h1234_5678 || gl[0] !== 1'b0) begin
            bad++; $display("FAIL bp_w0: got %h last=%b want 12345678 last=0", got[0], gl[0]); end
         total++; if (got[1] !== 32'hDEAD_BEEF || gl[1] !== 1'b0) begin
            bad++; $display("FAIL bp_w1: got %h last=%b want deadbeef last=0", got[1], gl[1]); end
         total++; if (got[2] !== 32'h0000_002B || gl[2] !== 1'b1) begin
            bad++; $display("FAIL bp_w2: got %h last=%b want 0000002b last=1", got[2], gl[2]); end
      end
   endtask

   task automatic test_zero;
      word_ready = 1'b1;
      @(negedge clk);
      req_start = 10'd7; req_count = 11'd0; req_valid = 1'b1;
      @(negedge clk); req_valid = 1'b0;
      total++; if (done !== 1'b1 || word_valid !== 1'b0 || req_ready !== 1'b0) begin
         bad++; $display("FAIL zero_done: got done=%b v=%b rdy=%b want 1 0 0", done, word_valid, req_ready); end
      @(negedge clk);
      total++; if (done !== 1'b0 || word_valid !== 1'b0 || req_ready !== 1'b1) begin
         bad++; $display("FAIL zero_idle: got done=%b v=%b rdy=%b want 0 0 1", done, word_valid, req_ready); end
   endtask

   task automatic test_lat_reset;
      int n;
      logic [9:0] exp_sel;
      in_vec = '0; in_vec[36:5] = 32'hCAFE_F00D; b_word_ready = 1'b0;
      @(negedge clk);
      b_req_start = 10'd5; b_req_count = 11'd40; b_req_valid = 1'b1;
      @(negedge clk); b_req_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         exp_sel = 10'(5 + i / 3);
         total++; if (b_sel_o !== exp_sel) begin bad++; $display("FAIL lat_sel%0d: got %0d want %0d", i, b_sel_o, exp_sel); end
      end
      n = 0;
      while (!b_word_valid && n < 200) begin @(negedge clk); n++; end
      total++; if (b_word_valid !== 1'b1 || b_word_data !== 32'hCAFE_F00D) begin
         bad++; $display("FAIL lat_word: got v=%b %h want v=1 cafef00d", b_word_valid, b_word_data); end
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++; if ({b_sel_o, b_word_valid, b_word_last, b_done, b_busy} !== 14'd0 || b_word_data !== 32'd0) begin
         bad++; $display("FAIL lat_reset: got sel=%0d v=%b d=%h l=%b done=%b b=%b want all 0",
                         b_sel_o, b_word_valid, b_word_data, b_word_last, b_done, b_busy); end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      in_vec[3:0] = 4'b1010; b_word_ready = 1'b1;
      @(negedge clk); @(negedge clk);
      b_req_start = 10'd0; b_req_count = 11'd4; b_req_valid = 1'b1;
      @(negedge clk); b_req_valid = 1'b0;
      n = 0;
      while (!b_word_valid && n < 100) begin @(negedge clk); n++; end
      total++; if (b_word_valid !== 1'b1 || b_word_data !== 32'h0000_000A || b_word_last !== 1'b1) begin
         bad++; $display("FAIL lat_restart: got v=%b %h l=%b want v=1 0000000a l=1", b_word_valid, b_word_data, b_word_last); end
      n = 0;
      while (b_busy && n < 50) begin @(negedge clk); n++; end
   endtask

`ifdef MUX_SCAN_PARITY_EN
   task automatic test_parity;
      int n;
      word_ready = 1'b1;
      in_vec = '0; in_vec[2:0] = 3'b111;
      @(negedge clk); @(negedge clk);
      req_start = 10'd0; req_count = 11'd3; req_valid = 1'b1;
      @(negedge clk); req_valid = 1'b0;
      n = 0;
      while (!word_valid && n < 50) begin @(negedge clk); n++; end
      total++; if (word_data !== 32'h0000_0007 || word_par !== 1'b1) begin
         bad++; $display("FAIL par_odd: got %h par=%b want 00000007 par=1", word_data, word_par); end
      n = 0;
      while (busy && n < 50) begin @(negedge clk); n++; end
      in_vec[2:0] = 3'b011;
      @(negedge clk); @(negedge clk);
      req_start = 10'd0; req_count = 11'd2; req_valid = 1'b1;
      @(negedge clk); req_valid = 1'b0;
      n = 0;
      while (!word_valid && n < 50) begin @(negedge clk); n++; end
      total++; if (word_data !== 32'h0000_0003 || word_par !== 1'b0) begin
         bad++; $display("FAIL par_even: got %h par=%b want 00000003 par=0", word_data, word_par); end
      n = 0;
      while (busy && n < 50) begin @(negedge clk); n++; end
   endtask
`endif

   initial begin
      req_valid = 1'b0; req_start = '0; req_count = '0; word_ready = 1'b0;
      b_req_valid = 1'b0; b_req_start = '0; b_req_count = '0; b_word_ready = 1'b0;
      test_reset;
      test_basic;
      test_wrap;
      test_backpressure;
      test_zero;
      test_lat_reset;
`ifdef MUX_SCAN_PARITY_EN
      test_parity;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
